// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared mode encodings and compose FSM states
package mips_pkg;

    typedef enum logic [1:0] {
        MODE_ZEXT    = 2'b00,
        MODE_SEXT    = 2'b01,
        MODE_LUI     = 2'b10,
        MODE_COMPOSE = 2'b11
    } imm_mode_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } compose_state_e;

endpackage

// File: rtl/imm_extend.sv
// rtl/imm_extend.sv - combinational ZEXT/SEXT/LUI immediate extension
module imm_extend
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16
) (
    input  logic [1:0]        i_mode,
    input  logic [IMM_W-1:0]  i_immediate,
    output logic [DATA_W-1:0] o_ext
);

    logic [DATA_W-1:0] w_zext;
    logic [DATA_W-1:0] w_sext;
    logic [DATA_W-1:0] w_lui;

    assign w_zext = {{(DATA_W-IMM_W){1'b0}}, i_immediate};
    assign w_sext = {{(DATA_W-IMM_W){i_immediate[IMM_W-1]}}, i_immediate};
    // Shifting the sign-extended value leaves the field at [2*IMM_W-1:IMM_W],
    // zeros below and sign copies above, for any legal DATA_W.
    assign w_lui  = w_sext << IMM_W;

    // Select the extension for the requested mode; COMPOSE never uses this path.
    always_comb begin
        o_ext = w_zext;
        case (imm_mode_e'(i_mode))
            MODE_SEXT: o_ext = w_sext;
            MODE_LUI:  o_ext = w_lui;
            default:   o_ext = w_zext;
        endcase
    end

endmodule

// File: rtl/imm_compose_unit.sv
// rtl/imm_compose_unit.sv - immediate extension and multi-beat constant composer
module imm_compose_unit
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        mode,
    input  logic              last,
    input  logic [IMM_W-1:0]  immediate,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
    output logic              abort
);

    compose_state_e    r_state;
    compose_state_e    w_state_next;
    logic [DATA_W-1:0] r_acc;
    logic [DATA_W-1:0] r_result;
    logic              r_out_valid;
    logic              r_abort;

    logic              w_accept;
    logic              w_is_compose;
    logic              w_produce;
    logic              w_abort_set;
    logic [DATA_W-1:0] w_ext;
    logic [DATA_W-1:0] w_acc_base;
    logic [DATA_W-1:0] w_acc_new;
    logic [DATA_W-1:0] w_next_result;

    imm_extend #(
        .DATA_W (DATA_W),
        .IMM_W  (IMM_W)
    ) u_extend (
        .i_mode      (mode),
        .i_immediate (immediate),
        .o_ext       (w_ext)
    );

    // The output register can take a new value whenever it is empty or being drained.
    assign in_ready     = !r_out_valid || out_ready;
    assign w_accept     = in_valid && in_ready;
    assign w_is_compose = (mode == MODE_COMPOSE);

    // A fresh constant starts from zero; older beats fall off the top when overfilled.
    assign w_acc_base = (r_state == ST_ACCUM) ? r_acc : '0;
    assign w_acc_new  = (w_acc_base << IMM_W) | {{(DATA_W-IMM_W){1'b0}}, immediate};

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_next;
    end

    // FSM next state: only a non-last COMPOSE beat leaves or keeps us in ACCUM.
    always_comb begin
        w_state_next = r_state;
        if (w_accept) begin
            if (w_is_compose && !last) w_state_next = ST_ACCUM;
            else                       w_state_next = ST_IDLE;
        end
    end

    // FSM outputs: what the accepted beat produces and whether it kills a sequence.
    always_comb begin
        w_produce     = 1'b0;
        w_abort_set   = 1'b0;
        w_next_result = w_ext;
        if (w_accept) begin
            if (w_is_compose) begin
                w_produce     = last;
                w_next_result = w_acc_new;
            end else begin
                w_produce   = 1'b1;
                w_abort_set = (r_state == ST_ACCUM);
            end
        end
    end

    // Accumulator: grows on COMPOSE beats, dropped when another mode interrupts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (w_accept) begin
            if (w_is_compose) r_acc <= w_acc_new;
            else              r_acc <= '0;
        end
    end

    // Output register and abort pulse; result only changes when a beat produces.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result    <= '0;
            r_out_valid <= 1'b0;
            r_abort     <= 1'b0;
        end else begin
            r_abort <= w_abort_set;
            if (w_produce) begin
                r_result    <= w_next_result;
                r_out_valid <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign abort     = r_abort;

endmodule

// File: tb/tb_imm_compose_unit.sv
// tb/tb_imm_compose_unit.sv - directed self-checking bench for imm_compose_unit
module tb_imm_compose_unit;

    localparam logic [1:0] ZEXT    = 2'b00;
    localparam logic [1:0] SEXT    = 2'b01;
    localparam logic [1:0] LUI     = 2'b10;
    localparam logic [1:0] COMPOSE = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        a_in_valid, a_in_ready, a_last, a_out_valid, a_out_ready, a_abort;
    logic [1:0]  a_mode;
    logic [15:0] a_imm;
    logic [31:0] a_result;

    logic        b_in_valid, b_in_ready, b_last, b_out_valid, b_out_ready, b_abort;
    logic [1:0]  b_mode;
    logic [15:0] b_imm;
    logic [63:0] b_result;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    imm_compose_unit #(.DATA_W(32), .IMM_W(16)) u_dut32 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .mode      (a_mode),
        .last      (a_last),
        .immediate (a_imm),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .result    (a_result),
        .abort     (a_abort)
    );

    imm_compose_unit #(.DATA_W(64), .IMM_W(16)) u_dut64 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .mode      (b_mode),
        .last      (b_last),
        .immediate (b_imm),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .result    (b_result),
        .abort     (b_abort)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic v, input logic [1:0] m, input logic l, input logic [15:0] d);
        a_in_valid = v; a_mode = m; a_last = l; a_imm = d;
    endtask

    task automatic drive_b(input logic v, input logic [1:0] m, input logic l, input logic [15:0] d);
        b_in_valid = v; b_mode = m; b_last = l; b_imm = d;
    endtask

    initial begin
        rst_n = 1'b0;
        drive_a(1'b0, ZEXT, 1'b0, 16'h0); a_out_ready = 1'b1;
        drive_b(1'b0, ZEXT, 1'b0, 16'h0); b_out_ready = 1'b1;
        tick(); tick();
        check_eq("rst_out_valid", a_out_valid, 0);
        check_eq("rst_result",    a_result,    0);
        check_eq("rst_abort",     a_abort,     0);
        check_eq("rst_in_ready",  a_in_ready,  1);
        rst_n = 1'b1;

        // LUI on the very first edge after reset
        drive_a(1'b1, LUI, 1'b0, 16'h1234);
        tick();
        check_eq("lui_valid",  a_out_valid, 1);
        check_eq("lui_result", a_result, 32'h1234_0000);

        // SEXT then ZEXT back to back
        drive_a(1'b1, SEXT, 1'b0, 16'h8001);
        tick();
        check_eq("sext_result", a_result, 32'hFFFF_8001);
        drive_a(1'b1, ZEXT, 1'b0, 16'h8001);
        tick();
        check_eq("zext_result", a_result, 32'h0000_8001);
        check_eq("zext_valid",  a_out_valid, 1);
        drive_a(1'b0, ZEXT, 1'b0, 16'h0);
        tick();
        check_eq("drain_valid", a_out_valid, 0);

        // two-beat COMPOSE
        drive_a(1'b1, COMPOSE, 1'b0, 16'hDEAD);
        tick();
        check_eq("cmp_mid_valid", a_out_valid, 0);
        drive_a(1'b1, COMPOSE, 1'b1, 16'hBEEF);
        tick();
        check_eq("cmp_valid",  a_out_valid, 1);
        check_eq("cmp_result", a_result, 32'hDEAD_BEEF);

        // single-beat COMPOSE equals ZEXT
        drive_a(1'b1, COMPOSE, 1'b1, 16'h8001);
        tick();
        check_eq("cmp1_result", a_result, 32'h0000_8001);

        // COMPOSE interrupted by LUI
        drive_a(1'b1, COMPOSE, 1'b0, 16'hAAAA);
        tick();
        check_eq("abort_pre", a_abort, 0);
        drive_a(1'b1, LUI, 1'b0, 16'h0001);
        tick();
        check_eq("abort_pulse",  a_abort, 1);
        check_eq("abort_result", a_result, 32'h0001_0000);
        drive_a(1'b0, ZEXT, 1'b0, 16'h0);
        tick();
        check_eq("abort_once", a_abort, 0);

        // three beats overflow a 32-bit result: oldest beat shifted out
        drive_a(1'b1, COMPOSE, 1'b0, 16'h1111); tick();
        drive_a(1'b1, COMPOSE, 1'b0, 16'h2222); tick();
        drive_a(1'b1, COMPOSE, 1'b1, 16'h3333); tick();
        check_eq("ovf_result", a_result, 32'h2222_3333);
        drive_a(1'b0, ZEXT, 1'b0, 16'h0); tick();

        // backpressure: result held, queued beat lands after release
        a_out_ready = 1'b0;
        drive_a(1'b1, ZEXT, 1'b0, 16'h5555);
        tick();
        check_eq("bp_first", a_result, 32'h0000_5555);
        drive_a(1'b1, ZEXT, 1'b0, 16'h6666);
        #1;
        check_eq("bp_in_ready", a_in_ready, 0);
        tick();
        check_eq("bp_hold1", a_result, 32'h0000_5555);
        tick();
        check_eq("bp_hold2",  a_result, 32'h0000_5555);
        check_eq("bp_valid",  a_out_valid, 1);
        a_out_ready = 1'b1;
        #1;
        check_eq("bp_release_ready", a_in_ready, 1);
        tick();
        check_eq("bp_release_result", a_result, 32'h0000_6666);
        check_eq("bp_release_valid",  a_out_valid, 1);
        drive_a(1'b0, ZEXT, 1'b0, 16'h0);
        tick();
        check_eq("bp_drained", a_out_valid, 0);

        // 64-bit instance
        drive_b(1'b1, LUI, 1'b0, 16'h8000);
        tick();
        check_eq("w64_lui", b_result, 64'hFFFF_FFFF_8000_0000);
        drive_b(1'b1, COMPOSE, 1'b0, 16'h0123); tick();
        drive_b(1'b1, COMPOSE, 1'b0, 16'h4567); tick();
        drive_b(1'b1, COMPOSE, 1'b0, 16'h89AB); tick();
        drive_b(1'b1, COMPOSE, 1'b1, 16'hCDEF); tick();
        check_eq("w64_cmp_valid",  b_out_valid, 1);
        check_eq("w64_cmp_result", b_result, 64'h0123_4567_89AB_CDEF);
        drive_b(1'b0, ZEXT, 1'b0, 16'h0); tick();

        // reset in the middle of a COMPOSE sequence
        drive_b(1'b1, COMPOSE, 1'b0, 16'h1111); tick();
        drive_b(1'b1, COMPOSE, 1'b0, 16'h2222); tick();
        check_eq("w64_mid_valid", b_out_valid, 0);
        drive_b(1'b0, ZEXT, 1'b0, 16'h0);
        rst_n = 1'b0;
        #1;
        check_eq("w64_rst_valid",  b_out_valid, 0);
        check_eq("w64_rst_abort",  b_abort, 0);
        check_eq("w64_rst_result", b_result, 0);
        tick();
        rst_n = 1'b1;
        tick();
        check_eq("w64_post_abort", b_abort, 0);
        check_eq("w64_post_valid", b_out_valid, 0);
        drive_b(1'b1, COMPOSE, 1'b1, 16'h0007);
        tick();
        check_eq("w64_fresh_result", b_result, 64'h7);
        check_eq("w64_fresh_abort",  b_abort, 0);
        drive_b(1'b0, ZEXT, 1'b0, 16'h0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/imm_compose_unit.md
IMM_COMPOSE_UNIT -- requirements
Module: imm_compose_unit

Interface
REQ-001 Parameter DATA_W, default 32, result width; SHALL be a multiple of IMM_W and at least 2*IMM_W.
REQ-002 Parameter IMM_W, default 16, immediate field width.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port in_valid  input  1  request beat present.
REQ-006 Port in_ready  output  1  unit accepts beat this cycle.
REQ-007 Port mode  input  2  00 ZEXT, 01 SEXT, 10 LUI, 11 COMPOSE.
REQ-008 Port last  input  1  COMPOSE only: final beat of a constant.
REQ-009 Port immediate  input  IMM_W  immediate field.
REQ-010 Port out_valid  output  1  result register holds a valid result.
REQ-011 Port out_ready  input  1  consumer accepts result.
REQ-012 Port result  output  DATA_W  generated constant.
REQ-013 Port abort  output  1  one-cycle pulse: open COMPOSE sequence discarded.

Function
REQ-014 A beat SHALL be accepted when in_valid && in_ready; in_ready SHALL equal !out_valid || out_ready (combinational, no dependence on in_valid).
REQ-015 ZEXT SHALL produce immediate zero-extended to DATA_W.
REQ-016 SEXT SHALL produce immediate sign-extended from bit IMM_W-1.
REQ-017 LUI SHALL produce immediate at bits [2*IMM_W-1:IMM_W], zeros below, bits above sign-extended from immediate[IMM_W-1]; at DATA_W=32 this is {immediate, 16'd0}.
REQ-018 ZEXT/SEXT/LUI accepted beats SHALL load result and set out_valid on the next edge (latency 1).
REQ-019 COMPOSE SHALL use FSM IDLE/ACCUM: accepted beat updates acc <= (acc << IMM_W) | immediate (acc cleared first when in IDLE); last=0 -> ACCUM, no output; last=1 -> result <= new acc, out_valid set, FSM -> IDLE.
REQ-020 COMPOSE beats beyond DATA_W/IMM_W SHALL shift oldest bits out of the top (no saturation, no error).
REQ-021 Single-beat COMPOSE (last=1 in IDLE) SHALL equal ZEXT of immediate.
REQ-022 Non-COMPOSE beat accepted in ACCUM SHALL discard acc, pulse abort the following cycle, return FSM to IDLE, and process the beat per its own mode.
REQ-023 Non-last COMPOSE beats SHALL be accepted even while out_valid && !out_ready only if in_ready is high (REQ-014 governs all modes uniformly).
REQ-024 out_valid SHALL clear on out_valid && out_ready with no new producing beat; simultaneous accept-and-produce SHALL keep out_valid high and load the new result (full throughput, one result per cycle).
REQ-025 result SHALL hold stable while out_valid && !out_ready.
REQ-026 Reserved behaviour: none; all four mode codes are defined.

Reset
REQ-027 rst_n low SHALL asynchronously force out_valid=0, abort=0, result=0, acc=0, FSM=IDLE.
REQ-028 Reset asserted mid-COMPOSE SHALL discard the partial constant without an abort pulse.
REQ-029 First beat SHALL be accepted on the first rising edge after rst_n deasserts.

Structure
REQ-030 Mode encodings and FSM state enum SHALL live in the shared mips_pkg package.
REQ-031 Extension logic (ZEXT/SEXT/LUI) SHALL be one combinational sub-module imm_extend, parameterised by DATA_W and IMM_W; FSM, acc and output register stay in the top.

Verification
REQ-032 LUI 0x1234, out_ready=1 -> next cycle out_valid=1, result=0x12340000.
REQ-033 SEXT 0x8001 then ZEXT 0x8001 back-to-back -> results 0xFFFF8001 then 0x00008001 on consecutive cycles.
REQ-034 COMPOSE 0xDEAD last=0, COMPOSE 0xBEEF last=1 -> single result 0xDEADBEEF, no output after first beat.
REQ-035 COMPOSE 0xAAAA last=0, then LUI 0x0001 -> abort pulses once, result=0x00010000.
REQ-036 out_ready=0 with result held, drive beats -> in_ready=0, result unchanged; release -> queued beat result appears next cycle.
REQ-037 DATA_W=64: LUI 0x8000 -> 0xFFFFFFFF80000000; four COMPOSE beats 0x0123,0x4567,0x89AB,0xCDEF -> 0x0123456789ABCDEF; rst_n low after two beats -> no output, no abort.
